// File: rtl/bert_fetch_pkg.sv
// bert_fetch_pkg
// Shared constants for the Q/K/V fetch path: buffer-select codes, tiling
// encodings, the scheduler FSM state type and the step -> (select, tiling)
// mapping, so read-side and write-side controllers agree on encodings.
package bert_fetch_pkg;

  localparam logic [2:0] SEL_K    = 3'b100;
  localparam logic [2:0] SEL_Q    = 3'b011;
  localparam logic [2:0] SEL_V    = 3'b101;

  localparam logic       TILE_32  = 1'b1;
  localparam logic       TILE_512 = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DONE
  } fetch_state_e;

  // Even steps below the last fetch K, odd steps fetch Q, the last step fetches V.
  function automatic logic [2:0] step_sel(input int unsigned step, input int unsigned last);
    if (step == last)         return SEL_V;
    else if ((step % 2) != 0) return SEL_Q;
    else                      return SEL_K;
  endfunction

  function automatic logic step_tiles(input int unsigned step, input int unsigned last);
    if (step != last && (step % 2) == 0) return TILE_32;
    else                                 return TILE_512;
  endfunction

endpackage

// File: rtl/qkv_fetch_scheduler.sv
// qkv_fetch_scheduler
// Sequences the Q/K/V fetch engine for one attention pass: K(32) -> Q(512)
// repeated NUM_PASSES times, then V(512). Each fetch is preceded by a setup
// window holding select/tiling stable, gated on consumer readiness and engine
// idleness, and watchdogged while outstanding.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sched_start         begin a sequence (only honoured when idle)
//   sched_abort         abandon the sequence, return to idle
//   sa_ready            consumer can accept a new tile stream
//   fetch_done          engine completion (rising edge counts)
//   fetch_busy          engine busy
//   start_fetch         one-cycle fetch launch pulse
//   Buffer_Select       K/Q/V buffer select code
//   Tiles_Control       1 = tiling 32, 0 = tiling 512
//   reset_addr_counter  held during setup of step 0 and of the V step
//   sched_busy          sequence in progress
//   sched_done          one-cycle pulse after V completes
//   sched_error         sticky watchdog flag
//   step_idx            current fetch index
module qkv_fetch_scheduler
  import bert_fetch_pkg::*;
#(
  parameter int unsigned NUM_PASSES     = 2,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 262143,
  localparam int unsigned STEP_W        = $clog2(2 * NUM_PASSES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_start,
  input  logic              sched_abort,
  input  logic              sa_ready,
  input  logic              fetch_done,
  input  logic              fetch_busy,
  output logic              start_fetch,
  output logic [2:0]        Buffer_Select,
  output logic              Tiles_Control,
  output logic              reset_addr_counter,
  output logic              sched_busy,
  output logic              sched_done,
  output logic              sched_error,
  output logic [STEP_W-1:0] step_idx
);

  localparam int unsigned LAST_STEP = 2 * NUM_PASSES;
  localparam int unsigned SETUP_W   = $clog2(SETUP_CYCLES + 1);
  localparam int unsigned WD_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_LIMIT  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [STEP_W-1:0]  LAST_IDX  = STEP_W'(LAST_STEP);
  localparam logic [SETUP_W-1:0] SETUP_END = SETUP_W'(SETUP_CYCLES - 1);
  localparam logic [WD_W-1:0]    WD_END    = WD_W'(WD_LIMIT);

  fetch_state_e        state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [SETUP_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                err_q, err_d;
  logic                fetch_done_q, fetch_done_d;
  logic                start_fetch_q, start_fetch_d;
  logic [2:0]          sel_q, sel_d;
  logic                tiles_q, tiles_d;
  logic                rac_q, rac_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                issue;
  logic                done_rise;
  logic                timeout;

  assign done_rise = fetch_done && !fetch_done_q;
  assign timeout   = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      setup_cnt_q   <= '0;
      wd_cnt_q      <= '0;
      err_q         <= 1'b0;
      fetch_done_q  <= 1'b0;
      start_fetch_q <= 1'b0;
      sel_q         <= '0;
      tiles_q       <= 1'b0;
      rac_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      setup_cnt_q   <= setup_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      err_q         <= err_d;
      fetch_done_q  <= fetch_done_d;
      start_fetch_q <= start_fetch_d;
      sel_q         <= sel_d;
      tiles_q       <= tiles_d;
      rac_q         <= rac_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // The issue decision is taken on the last SETUP cycle as well as in ISSUE,
  // so the registered start_fetch lands exactly SETUP_CYCLES after setup began;
  // ISSUE is only occupied while the launch is stalled.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    setup_cnt_d  = setup_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    err_d        = err_q;
    fetch_done_d = fetch_done;
    issue        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sched_start) begin
          state_d     = ST_SETUP;
          step_d      = '0;
          setup_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      ST_SETUP, ST_ISSUE: begin
        if (state_q == ST_ISSUE || setup_cnt_q == SETUP_END) begin
          if (sa_ready && !fetch_busy) begin
            issue    = 1'b1;
            state_d  = ST_WAIT_DONE;
            wd_cnt_d = '0;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (done_rise) begin
          if (step_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_SETUP;
            step_d      = step_q + 1'b1;
            setup_cnt_d = '0;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything and leaves step, counters and error untouched.
    if (sched_abort) begin
      state_d     = ST_IDLE;
      step_d      = step_q;
      setup_cnt_d = setup_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      err_d       = err_q;
      issue       = 1'b0;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    start_fetch_d = issue;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    rac_d         = (state_d == ST_SETUP) && (step_d == '0 || step_d == LAST_IDX);
    sel_d         = sel_q;
    tiles_d       = tiles_q;
    if (state_d == ST_SETUP) begin
      sel_d   = step_sel(32'(step_d), LAST_STEP);
      tiles_d = step_tiles(32'(step_d), LAST_STEP);
    end
  end

  assign start_fetch        = start_fetch_q;
  assign Buffer_Select      = sel_q;
  assign Tiles_Control      = tiles_q;
  assign reset_addr_counter = rac_q;
  assign sched_busy         = busy_q;
  assign sched_done         = done_q;
  assign sched_error        = err_q;
  assign step_idx           = step_q;

endmodule

// File: tb/tb_qkv_fetch_scheduler.sv
module tb_qkv_fetch_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sched_start = 1'b0;
  logic       sched_abort = 1'b0;
  logic       sa_ready = 1'b1;
  logic       fetch_done = 1'b0;
  logic       fetch_busy = 1'b0;
  logic       start_fetch;
  logic [2:0] Buffer_Select;
  logic       Tiles_Control;
  logic       reset_addr_counter;
  logic       sched_busy;
  logic       sched_done;
  logic       sched_error;
  logic [2:0] step_idx;

  qkv_fetch_scheduler #(
    .NUM_PASSES    (2),
    .SETUP_CYCLES  (2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sched_start       (sched_start),
    .sched_abort       (sched_abort),
    .sa_ready          (sa_ready),
    .fetch_done        (fetch_done),
    .fetch_busy        (fetch_busy),
    .start_fetch       (start_fetch),
    .Buffer_Select     (Buffer_Select),
    .Tiles_Control     (Tiles_Control),
    .reset_addr_counter(reset_addr_counter),
    .sched_busy        (sched_busy),
    .sched_done        (sched_done),
    .sched_error       (sched_error),
    .step_idx          (step_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int step;
    int at;
    int sel;
    int tiles;
    int rac;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int t_sel[5];
  int t_tiles[5];
  int t_rac[5];
  int rac_seen = 0;
  int err_prev = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int step, input int at);
    exp_t e;
    e.kind  = kind;
    e.step  = step;
    e.at    = at;
    e.sel   = (kind == K_START) ? t_sel[step] : 0;
    e.tiles = (kind == K_START) ? t_tiles[step] : 0;
    e.rac   = (kind == K_START) ? t_rac[step] : 0;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: actual kind=%0d required=none (cyc %0d)", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      if (kind == K_START) begin
        chk("start_sel", int'(Buffer_Select), e.sel);
        chk("start_tiles", int'(Tiles_Control), e.tiles);
        chk("start_step", int'(step_idx), e.step);
        chk("rac_in_setup", rac_seen, e.rac);
        rac_seen = 0;
      end
    end
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      err_prev = 0;
    end else begin
      if (reset_addr_counter) rac_seen = 1;
      if (start_fetch) take(K_START);
      if (sched_done) take(K_DONE);
      if (sched_error && err_prev == 0) take(K_ERR);
      err_prev = int'(sched_error);
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One full sequence; optionally stall one step (kind 1 = sa_ready low,
  // kind 2 = fetch_busy high), hold fetch_done high across steps, or abort.
  task automatic run_sequence(input int stall_step, input int stall_kind,
                              input bit stuck, input int abort_step);
    int st;
    int e;
    sched_start = 1'b1;
    @(negedge clk);
    sched_start = 1'b0;
    chk("error_cleared", int'(sched_error), 0);
    chk("busy_on_start", int'(sched_busy), 1);
    chk("setup0_sel", int'(Buffer_Select), 4);
    chk("setup0_rac", int'(reset_addr_counter), 1);
    chk("setup0_step", int'(step_idx), 0);
    st = cyc + 2;
    e  = st;
    for (int i = 0; i < 5; i++) begin
      push(K_START, i, (i == stall_step) ? st + 7 : st);
      if (i == stall_step) begin
        goto(st - 1);
        if (stall_kind == 1) sa_ready = 1'b0;
        else fetch_busy = 1'b1;
        goto(st + 3);
        chk("stall_sel", int'(Buffer_Select), t_sel[i]);
        chk("stall_no_start", int'(start_fetch), 0);
        goto(st + 6);
        sa_ready   = 1'b1;
        fetch_busy = 1'b0;
        st = st + 7;
      end
      if (i == abort_step) begin
        goto(st + 4);
        sched_abort = 1'b1;
        @(negedge clk);
        sched_abort = 1'b0;
        chk("abort_busy", int'(sched_busy), 0);
        chk("abort_step_kept", int'(step_idx), i);
        goto(st + 10);
        fetch_done = 1'b1;
        @(negedge clk);
        fetch_done = 1'b0;
        goto(st + 30);
        chk("abort_idle", int'(sched_busy), 0);
        return;
      end
      if (stuck) begin
        goto(st + 5);
        fetch_done = 1'b0;
      end
      if (i == 1) begin
        goto(st + 8);
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
      end
      e = st + 20;
      if (i == 4) push(K_DONE, 0, e);
      goto(e - 1);
      fetch_done = 1'b1;
      if (!stuck) begin
        @(negedge clk);
        fetch_done = 1'b0;
      end
      st = e + 2;
    end
    goto(e);
    chk("busy_in_done", int'(sched_busy), 1);
    goto(e + 1);
    chk("busy_after_done", int'(sched_busy), 0);
    fetch_done = 1'b0;
    goto(e + 4);
  endtask

  initial begin
    int st;
    t_sel   = '{4, 3, 4, 3, 5};
    t_tiles = '{1, 0, 1, 0, 0};
    t_rac   = '{1, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_start_fetch", int'(start_fetch), 0);
    chk("rst_sel", int'(Buffer_Select), 0);
    chk("rst_tiles", int'(Tiles_Control), 0);
    chk("rst_rac", int'(reset_addr_counter), 0);
    chk("rst_busy", int'(sched_busy), 0);
    chk("rst_done", int'(sched_done), 0);
    chk("rst_error", int'(sched_error), 0);
    chk("rst_step", int'(step_idx), 0);
    repeat (2) @(negedge clk);

    run_sequence(-1, 0, 1'b0, -1);
    chk("idle_holds_sel", int'(Buffer_Select), 5);
    run_sequence(1, 1, 1'b0, -1);
    run_sequence(3, 2, 1'b0, -1);
    run_sequence(-1, 0, 1'b1, -1);

    // Watchdog: no fetch_done after the first launch.
    sched_start = 1'b1;
    @(negedge clk);
    sched_start = 1'b0;
    st = cyc + 2;
    push(K_START, 0, st);
    push(K_ERR, 0, st + 50);
    goto(st + 49);
    chk("wd_busy_before", int'(sched_busy), 1);
    goto(st + 50);
    chk("wd_busy_after", int'(sched_busy), 0);
    goto(st + 55);
    chk("wd_error_sticky", int'(sched_error), 1);
    run_sequence(-1, 0, 1'b0, -1);

    run_sequence(-1, 0, 1'b0, 2);
    run_sequence(-1, 0, 1'b0, -1);

    // Asynchronous reset in the middle of SETUP.
    sched_start = 1'b1;
    @(negedge clk);
    sched_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_start_fetch", int'(start_fetch), 0);
    chk("arst_sel", int'(Buffer_Select), 0);
    chk("arst_tiles", int'(Tiles_Control), 0);
    chk("arst_rac", int'(reset_addr_counter), 0);
    chk("arst_busy", int'(sched_busy), 0);
    chk("arst_step", int'(step_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_sequence(-1, 0, 1'b0, -1);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
